// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state codes, WR encodings and timing helpers
// for the SCCB master.
package sccb_pkg;

    typedef logic [2:0] sccb_state_t;

    localparam sccb_state_t ST_IDLE    = 3'd0;
    localparam sccb_state_t ST_START   = 3'd1;
    localparam sccb_state_t ST_BIT     = 3'd2;
    localparam sccb_state_t ST_ACK     = 3'd3;
    localparam sccb_state_t ST_STOP    = 3'd4;
    localparam sccb_state_t ST_RESTART = 3'd5;
    localparam sccb_state_t ST_DONE    = 3'd6;

    localparam logic [1:0] WR_WRITE = 2'b01;
    localparam logic [1:0] WR_READ  = 2'b10;

    localparam int BITS_PER_BYTE = 9;

    function automatic logic [15:0] half_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

    function automatic logic [15:0] sda_delay(input logic [15:0] nd,
                                              input logic [15:0] h);
        return (nd > h - 16'd1) ? h - 16'd1 : nd;
    endfunction

endpackage

// File: rtl/sccb_clkgen.sv
// sccb_clkgen: half-period timer producing SCL edge and SDA update strobes.
// A zero SDA delay makes the SDA strobe coincide with the SCL fall.
module sccb_clkgen (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_en,
    input  logic [15:0] i_h,
    input  logic [15:0] i_d,
    output logic        o_scl_rise,
    output logic        o_scl_fall,
    output logic        o_sda_tick
);
    logic [15:0] r_cnt;
    logic        r_hi;
    logic        w_end;

    assign w_end      = i_en && (r_cnt == i_h - 16'd1);
    assign o_scl_fall = w_end && r_hi;
    assign o_scl_rise = w_end && !r_hi;
    assign o_sda_tick = (i_d == 16'd0) ? o_scl_fall
                      : (i_en && !r_hi && (r_cnt == i_d - 16'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_hi  <= 1'b1;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_hi  <= 1'b1;
        end else if (w_end) begin
            r_cnt <= '0;
            r_hi  <= !r_hi;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB 3-phase write and 2+2-phase read bus master.
// Define SCCB_ACK_CHECK_EN to abort on a slave NACK of a write byte.
module sccb_master
    import sccb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        Start,
    output logic        Busy,
    input  logic [31:0] DataOut,
    input  logic [1:0]  WR,
    input  logic [15:0] ClockDiv,
    input  logic [15:0] NegDel,
    output logic [31:0] DataIn,
    output logic        scl,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic        sda_i
);
    sccb_state_t r_state;
    logic [1:0]  r_wr;
    logic [6:0]  r_id;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdat;
    logic [7:0]  r_sh;
    logic [7:0]  r_rx;
    logic [7:0]  r_rdata;
    logic [15:0] r_h;
    logic [15:0] r_d;
    logic [2:0]  r_bit;
    logic [1:0]  r_byte;
    logic        r_stophi;
    logic        r_nack;
    logic        r_err;
    logic        r_scl;
    logic        r_sda_o;
    logic        r_sda_oe;

    logic        w_run;
    logic        w_rise;
    logic        w_fall;
    logic        w_tick;
    logic        w_accept;
    logic        w_rd_byte;
    logic        w_last;
    logic        w_ack_fail;
    logic        w_unused;
    logic [15:0] w_h;

    assign w_h       = half_period(ClockDiv);
    assign w_accept  = Start && (r_state == ST_IDLE)
                    && ((WR == WR_WRITE) || (WR == WR_READ));
    assign w_run     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_rd_byte = (r_byte == 2'd3);
    // Byte order: 0 ID, 1 register, 2 data (write) or {ID,1} (read), 3 read data
    assign w_last    = w_rd_byte || ((r_wr == WR_WRITE) ? (r_byte == 2'd2)
                                                        : (r_byte == 2'd1));
`ifdef SCCB_ACK_CHECK_EN
    assign w_ack_fail = !w_rd_byte && sda_i;
`else
    assign w_ack_fail = 1'b0;
`endif
    assign w_unused = ^{DataOut[31:24], DataOut[16]};

    assign Busy   = (r_state != ST_IDLE);
    assign scl    = r_scl;
    assign sda_o  = r_sda_o;
    assign sda_oe = r_sda_oe;
    assign DataIn = {r_err, 23'd0, r_rdata};

    sccb_clkgen u_clkgen (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (w_run),
        .i_h        (r_h),
        .i_d        (r_d),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_sda_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_wr     <= '0;
            r_id     <= '0;
            r_reg    <= '0;
            r_wdat   <= '0;
            r_sh     <= '0;
            r_rx     <= '0;
            r_rdata  <= '0;
            r_h      <= '0;
            r_d      <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_stophi <= 1'b0;
            r_nack   <= 1'b0;
            r_err    <= 1'b0;
            r_scl    <= 1'b1;
            r_sda_o  <= 1'b1;
            r_sda_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wr     <= WR;
                        r_id     <= DataOut[23:17];
                        r_reg    <= DataOut[15:8];
                        r_wdat   <= DataOut[7:0];
                        r_sh     <= {DataOut[23:17], 1'b0};
                        r_h      <= w_h;
                        r_d      <= sda_delay(NegDel, w_h);
                        r_bit    <= '0;
                        r_byte   <= '0;
                        r_nack   <= 1'b0;
                        r_err    <= 1'b0;
                        r_sda_oe <= 1'b1;
                        r_sda_o  <= 1'b0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_fall) begin
                        r_scl   <= 1'b0;
                        r_state <= ST_BIT;
                    end
                    if (w_tick)
                        r_sda_o <= r_sh[7];
                end
                ST_BIT: begin
                    if (w_fall)
                        r_scl <= 1'b0;
                    if (w_tick) begin
                        r_sda_oe <= !w_rd_byte;
                        r_sda_o  <= r_sh[7];
                    end
                    if (w_rise) begin
                        r_scl <= 1'b1;
                        r_sh  <= {r_sh[6:0], 1'b0};
                        r_rx  <= {r_rx[6:0], sda_i};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'(BITS_PER_BYTE - 2))
                            r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (w_fall)
                        r_scl <= 1'b0;
                    // Release for the slave's ACK; drive NA after a read byte
                    if (w_tick) begin
                        r_sda_oe <= w_rd_byte;
                        r_sda_o  <= 1'b1;
                    end
                    if (w_rise) begin
                        r_scl <= 1'b1;
                        if (w_last || w_ack_fail) begin
                            r_nack   <= w_ack_fail;
                            r_stophi <= 1'b0;
                            r_state  <= ST_STOP;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_sh    <= (r_byte == 2'd0) ? r_reg : r_wdat;
                            r_state <= ST_BIT;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_fall) begin
                        if (r_stophi) begin
                            r_sda_o <= 1'b1;
                            r_state <= (r_wr == WR_READ && r_byte == 2'd1
                                        && !r_nack) ? ST_RESTART : ST_DONE;
                        end else begin
                            r_scl <= 1'b0;
                        end
                    end
                    if (w_tick && !r_stophi) begin
                        r_sda_oe <= 1'b1;
                        r_sda_o  <= 1'b0;
                    end
                    if (w_rise) begin
                        r_scl    <= 1'b1;
                        r_stophi <= 1'b1;
                    end
                end
                ST_RESTART: begin
                    if (w_rise) begin
                        r_sda_o <= 1'b0;
                        r_sh    <= {r_id, 1'b1};
                        r_byte  <= 2'd2;
                        r_state <= ST_START;
                    end
                end
                ST_DONE: begin
                    r_scl    <= 1'b1;
                    r_sda_o  <= 1'b1;
                    r_sda_oe <= 1'b0;
                    r_err    <= r_nack;
                    if (r_wr == WR_READ && !r_nack)
                        r_rdata <= r_rx;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
